// File: rtl/ns_check_pkg.sv
// ns_check_pkg
//   Shared types for the package export/import conflict checker:
//   event kinds, namespaces, entry origins, diagnostic codes, FSM states
//   and the symbol-table entry record.
//   Entry field widths match the checker's default NAME_W/PKG_W; the
//   checker must be instantiated with those widths.
package ns_check_pkg;

    localparam int ENTRY_NAME_W = 16;
    localparam int ENTRY_PKG_W  = 4;

    typedef enum logic [1:0] {
        K_LOCAL  = 2'b00,
        K_WILD   = 2'b01,
        K_EXPORT = 2'b10,
        K_EOP    = 2'b11
    } kind_e;

    typedef enum logic {
        NS_VALUE = 1'b0,
        NS_TYPE  = 1'b1
    } ns_e;

    typedef enum logic [1:0] {
        O_LOCAL  = 2'b00,
        O_WILD   = 2'b01,
        O_EXPORT = 2'b10
    } origin_e;

    typedef enum logic [1:0] {
        C_NONE     = 2'b00,
        C_CONFLICT = 2'b01,
        C_OVERFLOW = 2'b10,
        C_SUMMARY  = 2'b11
    } code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_UPDATE,
        S_EMIT,
        S_CLEAR
    } state_e;

    typedef struct packed {
        logic                   valid;
        logic [ENTRY_NAME_W-1:0] name;
        ns_e                    ns;
        origin_e                origin;
        logic [ENTRY_PKG_W-1:0]  pkg;
    } entry_t;

endpackage

// File: rtl/ns_check_cam.sv
// ns_check_cam
//   Combinational DEPTH-way {name, ns} match plus lowest-index free-slot
//   finder over the symbol table.
//   Ports:
//     valid/names/nss : per-entry valid bit, name and namespace
//     key_name/key_ns : lookup key
//     hit, hit_idx    : key present and its slot
//     free_idx, full  : lowest free slot; no free slot at all
module ns_check_cam
    import ns_check_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                   valid,
    input  logic [DEPTH-1:0][ENTRY_NAME_W-1:0] names,
    input  logic [DEPTH-1:0]                   nss,
    input  logic [ENTRY_NAME_W-1:0]            key_name,
    input  logic                               key_ns,
    output logic                               hit,
    output logic [IDX_W-1:0]                   hit_idx,
    output logic [IDX_W-1:0]                   free_idx,
    output logic                               full
);

    // Scanned high to low so the lowest matching/free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        full     = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && names[i] == key_name && nss[i] == key_ns) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                full     = 1'b0;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ns_export_conflict_checker.sv
// ns_export_conflict_checker
//   Streams package symbol events (local decl, wildcard import, export,
//   end-of-package) into a small symbol table and reports export/import
//   collisions with local declarations, table overflow, and a per-package
//   entry-count summary. Value and type namespaces are kept apart.
//   Ports:
//     clk, rst_n                     : clock, async active-low reset
//     in_valid/in_ready              : event handshake
//     in_kind, in_ns, in_name, in_pkg: event fields
//     out_valid/out_ready            : diagnostic handshake
//     out_code, out_name, out_ns, out_pkg : diagnostic record
//     busy                           : FSM not idle
//   Optional: define NS_CHECK_COUNT_EN to add conflict_cnt, a saturating
//   16-bit count of transferred conflict diagnostics (reset-cleared only).
module ns_export_conflict_checker
    import ns_check_pkg::*;
#(
    parameter int NAME_W = 16,
    parameter int PKG_W  = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic              in_ns,
    input  logic [NAME_W-1:0] in_name,
    input  logic [PKG_W-1:0]  in_pkg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_code,
    output logic [NAME_W-1:0] out_name,
    output logic              out_ns,
    output logic [PKG_W-1:0]  out_pkg,
    output logic              busy
`ifdef NS_CHECK_COUNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e               state, state_nx;
    entry_t [DEPTH-1:0]   tbl;

    kind_e                ev_kind;
    logic                 ev_ns;
    logic [NAME_W-1:0]    ev_name;
    logic [PKG_W-1:0]     ev_pkg;

    logic                 lk_hit, lk_full;
    logic [IDX_W-1:0]     lk_idx, lk_free;

    logic                 cam_hit, cam_full;
    logic [IDX_W-1:0]     cam_hit_idx, cam_free_idx;
    logic [DEPTH-1:0]     tbl_valid, tbl_ns;
    logic [DEPTH-1:0][ENTRY_NAME_W-1:0] tbl_name;
    logic [CNT_W-1:0]     n_valid;

    code_e                out_code_q;

    always_comb begin
        n_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tbl_valid[i] = tbl[i].valid;
            tbl_name[i]  = tbl[i].name;
            tbl_ns[i]    = tbl[i].ns;
            n_valid      = n_valid + CNT_W'(tbl[i].valid);
        end
    end

    ns_check_cam #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_cam (
        .valid    (tbl_valid),
        .names    (tbl_name),
        .nss      (tbl_ns),
        .key_name (ENTRY_NAME_W'(ev_name)),
        .key_ns   (ev_ns),
        .hit      (cam_hit),
        .hit_idx  (cam_hit_idx),
        .free_idx (cam_free_idx),
        .full     (cam_full)
    );

    // ---------------------------------------------------------------
    // UPDATE-stage rule evaluation (uses the registered lookup result)
    // ---------------------------------------------------------------
    entry_t            hit_e, new_e;
    logic              upd_diag, wr_en;
    code_e             upd_code;
    logic [NAME_W-1:0] upd_name;
    logic [PKG_W-1:0]  upd_pkg;
    logic [IDX_W-1:0]  wr_idx;
    entry_t            wr_entry;

    assign hit_e = tbl[lk_idx];

    always_comb begin
        new_e = '{valid: 1'b1, name: ENTRY_NAME_W'(ev_name), ns: ns_e'(ev_ns),
                  origin: O_LOCAL, pkg: '0};
        upd_diag = 1'b0;
        upd_code = C_NONE;
        upd_name = ev_name;
        upd_pkg  = ev_pkg;
        wr_en    = 1'b0;
        wr_idx   = lk_idx;
        wr_entry = hit_e;
        case (ev_kind)
            K_LOCAL: begin
                if (lk_hit) begin
                    // A local always wins the slot; only a prior export is a clash.
                    wr_en           = 1'b1;
                    wr_entry.origin = O_LOCAL;
                    if (hit_e.origin == O_EXPORT) begin
                        upd_diag = 1'b1;
                        upd_code = C_CONFLICT;
                        upd_pkg  = PKG_W'(hit_e.pkg);
                    end
                end else if (lk_full) begin
                    upd_diag = 1'b1;
                    upd_code = C_OVERFLOW;
                end else begin
                    wr_en    = 1'b1;
                    wr_idx   = lk_free;
                    wr_entry = new_e;
                end
            end
            K_EXPORT: begin
                if (lk_hit) begin
                    if (hit_e.origin == O_WILD) begin
                        wr_en           = 1'b1;
                        wr_entry.origin = O_EXPORT;
                        wr_entry.pkg    = ENTRY_PKG_W'(ev_pkg);
                    end else if (hit_e.origin == O_LOCAL ||
                                 hit_e.pkg != ENTRY_PKG_W'(ev_pkg)) begin
                        // Reported package is the incoming export's.
                        upd_diag = 1'b1;
                        upd_code = C_CONFLICT;
                    end
                end else if (lk_full) begin
                    upd_diag = 1'b1;
                    upd_code = C_OVERFLOW;
                end else begin
                    wr_en        = 1'b1;
                    wr_idx       = lk_free;
                    wr_entry     = new_e;
                    wr_entry.origin = O_EXPORT;
                    wr_entry.pkg = ENTRY_PKG_W'(ev_pkg);
                end
            end
            K_WILD: begin
                // Wildcards never report; one that does not fit is simply dropped.
                if (!lk_hit && !lk_full) begin
                    wr_en        = 1'b1;
                    wr_idx       = lk_free;
                    wr_entry     = new_e;
                    wr_entry.origin = O_WILD;
                    wr_entry.pkg = ENTRY_PKG_W'(ev_pkg);
                end
            end
            default: begin
                upd_diag = 1'b1;
                upd_code = C_SUMMARY;
                upd_name = NAME_W'(n_valid);
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (in_valid) state_nx = S_LOOKUP;
            S_LOOKUP: state_nx = S_UPDATE;
            S_UPDATE: state_nx = upd_diag ? S_EMIT : S_IDLE;
            S_EMIT:   if (out_ready) state_nx = (ev_kind == K_EOP) ? S_CLEAR : S_IDLE;
            S_CLEAR:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_EMIT);
    assign busy      = (state != S_IDLE);
    assign out_code  = out_code_q;

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl        <= '0;
            ev_kind    <= K_LOCAL;
            ev_ns      <= 1'b0;
            ev_name    <= '0;
            ev_pkg     <= '0;
            lk_hit     <= 1'b0;
            lk_full    <= 1'b0;
            lk_idx     <= '0;
            lk_free    <= '0;
            out_code_q <= C_NONE;
            out_name   <= '0;
            out_ns     <= 1'b0;
            out_pkg    <= '0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                ev_kind <= kind_e'(in_kind);
                ev_ns   <= in_ns;
                ev_name <= in_name;
                ev_pkg  <= in_pkg;
            end
            if (state == S_LOOKUP) begin
                lk_hit  <= cam_hit;
                lk_full <= cam_full;
                lk_idx  <= cam_hit_idx;
                lk_free <= cam_free_idx;
            end
            if (state == S_UPDATE) begin
                if (wr_en) tbl[wr_idx] <= wr_entry;
                if (upd_diag) begin
                    out_code_q <= upd_code;
                    out_name   <= upd_name;
                    out_ns     <= ev_ns;
                    out_pkg    <= upd_pkg;
                end
            end
            if (state == S_CLEAR) begin
                for (int i = 0; i < DEPTH; i++) tbl[i].valid <= 1'b0;
            end
        end
    end

`ifdef NS_CHECK_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (state == S_EMIT && out_ready && out_code_q == C_CONFLICT &&
                 conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ns_export_conflict_checker.sv
// Bench for ns_export_conflict_checker: directed vector table, overflow /
// back-pressure and reset-mid-EMIT sequences, then random events checked
// against an associative-array model of the symbol table.
module tb_ns_export_conflict_checker;

    localparam int NAME_W = 16;
    localparam int PKG_W  = 4;
    localparam int DEPTH  = 16;

    localparam logic [1:0] KL = 2'b00, KW = 2'b01, KE = 2'b10, KP = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_kind = '0;
    logic              in_ns = 1'b0;
    logic [NAME_W-1:0] in_name = '0;
    logic [PKG_W-1:0]  in_pkg = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_code;
    logic [NAME_W-1:0] out_name;
    logic              out_ns;
    logic [PKG_W-1:0]  out_pkg;
    logic              busy;
`ifdef NS_CHECK_COUNT_EN
    logic [15:0]       conflict_cnt;
`endif

    always #5 clk = ~clk;

    ns_export_conflict_checker #(.NAME_W(NAME_W), .PKG_W(PKG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_ns(in_ns), .in_name(in_name), .in_pkg(in_pkg),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_name(out_name), .out_ns(out_ns), .out_pkg(out_pkg), .busy(busy)
`ifdef NS_CHECK_COUNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;
    int exp_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic send(input logic [1:0] k, input logic ns, input logic [15:0] nm,
                        input logic [3:0] pk);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 40) begin @(negedge clk); t++; end
        if (!in_ready) timeout("send_ready");
        in_valid = 1'b1; in_kind = k; in_ns = ns; in_name = nm; in_pkg = pk;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns at the negedge where either a diagnostic or idle is seen.
    task automatic wait_res(output logic got, output int lat);
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; lat = c; return; end
            if (in_ready)  begin lat = c; return; end
        end
        timeout("wait_result");
    endtask

    task automatic do_ev(input logic [1:0] k, input logic ns, input logic [15:0] nm,
                         input logic [3:0] pk, input int hold,
                         output logic got, output logic [1:0] code,
                         output logic [15:0] oname, output logic ons,
                         output logic [3:0] opkg, output int lat);
        send(k, ns, nm, pk);
        wait_res(got, lat);
        code = out_code; oname = out_name; ons = out_ns; opkg = out_pkg;
        if (got) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0] m_org [logic [16:0]];
    logic [3:0] m_pkg [logic [16:0]];

    task automatic model(input logic [1:0] k, input logic ns, input logic [15:0] nm,
                         input logic [3:0] pk, output logic ed, output logic [1:0] ec,
                         output logic [15:0] en, output logic [3:0] ep);
        logic [16:0] key = {ns, nm};
        ed = 1'b0; ec = 2'b00; en = nm; ep = pk;
        case (k)
            KL: if (m_org.exists(key)) begin
                    if (m_org[key] == 2'd2) begin ed = 1; ec = 2'b01; ep = m_pkg[key]; end
                    m_org[key] = 2'd0;
                end else if (m_org.num() == DEPTH) begin ed = 1; ec = 2'b10; end
                else begin m_org[key] = 2'd0; m_pkg[key] = 4'd0; end
            KW: if (!m_org.exists(key) && m_org.num() < DEPTH) begin
                    m_org[key] = 2'd1; m_pkg[key] = pk;
                end
            KE: if (m_org.exists(key)) begin
                    if (m_org[key] == 2'd1) begin m_org[key] = 2'd2; m_pkg[key] = pk; end
                    else if (m_org[key] == 2'd0 || m_pkg[key] != pk) begin ed = 1; ec = 2'b01; end
                end else if (m_org.num() == DEPTH) begin ed = 1; ec = 2'b10; end
                else begin m_org[key] = 2'd2; m_pkg[key] = pk; end
            default: begin
                ed = 1; ec = 2'b11; en = 16'(m_org.num());
                m_org.delete(); m_pkg.delete();
            end
        endcase
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic        ns;
        logic [15:0] name;
        logic [3:0]  pkg;
        logic        ed;
        logic [1:0]  ec;
        logic [15:0] en;
        logic        ens;
        logic [3:0]  ep;
    } vec_t;

    vec_t vq[$];

    initial begin
        logic got, ons, ed, ens;
        logic [1:0] code, ec;
        logic [15:0] oname, en, nm;
        logic [3:0] opkg, ep, pk;
        logic [1:0] k;
        int lat;

        // reset state
        #2;
        chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {out_code, out_name, out_ns, out_pkg}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        vq.push_back('{KE,0,16'h1234,1, 0,0,0,0,0});
        vq.push_back('{KL,0,16'h1234,0, 1,1,16'h1234,0,1});
        vq.push_back('{KP,0,0,0,        1,3,1,0,0});
        vq.push_back('{KE,0,16'h1234,1, 0,0,0,0,0});
        vq.push_back('{KE,1,16'h00AB,1, 0,0,0,0,0});
        vq.push_back('{KL,0,16'h1234,0, 1,1,16'h1234,0,1});
        vq.push_back('{KL,1,16'h00AB,0, 1,1,16'h00AB,1,1});
        vq.push_back('{KP,0,0,0,        1,3,2,0,0});
        vq.push_back('{KW,0,16'h0042,2, 0,0,0,0,0});
        vq.push_back('{KL,0,16'h0042,0, 0,0,0,0,0});
        vq.push_back('{KP,0,0,0,        1,3,1,0,0});
        vq.push_back('{KL,0,16'h1234,0, 0,0,0,0,0});
        vq.push_back('{KL,1,16'h1234,0, 0,0,0,0,0});
        vq.push_back('{KE,1,16'h1234,3, 1,1,16'h1234,1,3});
        vq.push_back('{KP,0,0,0,        1,3,2,0,0});
        vq.push_back('{KW,0,16'h0077,5, 0,0,0,0,0});
        vq.push_back('{KE,0,16'h0077,6, 0,0,0,0,0});
        vq.push_back('{KE,0,16'h0077,6, 0,0,0,0,0});
        vq.push_back('{KE,0,16'h0077,7, 1,1,16'h0077,0,7});
        vq.push_back('{KL,0,16'h0077,0, 1,1,16'h0077,0,6});
        vq.push_back('{KL,0,16'h0055,0, 0,0,0,0,0});
        vq.push_back('{KE,0,16'h0055,9, 1,1,16'h0055,0,9});
        vq.push_back('{KP,0,0,0,        1,3,2,0,0});

        foreach (vq[i]) begin
            do_ev(vq[i].kind, vq[i].ns, vq[i].name, vq[i].pkg, i % 3,
                  got, code, oname, ons, opkg, lat);
            chk($sformatf("vec%0d_diag", i), got, vq[i].ed);
            chk($sformatf("vec%0d_latency", i), lat, 3);
            if (vq[i].ed && got) begin
                chk($sformatf("vec%0d_code", i), code, vq[i].ec);
                chk($sformatf("vec%0d_name", i), oname, vq[i].en);
                if (vq[i].ec == 2'b01) begin
                    chk($sformatf("vec%0d_ns", i), ons, vq[i].ens);
                    chk($sformatf("vec%0d_pkg", i), opkg, vq[i].ep);
                    exp_cnt++;
                end
            end
        end

        // ---------------- overflow + back-pressure ----------------
        for (int i = 0; i < DEPTH; i++) begin
            do_ev(KL, 0, 16'h0100 + 16'(i), 0, 0, got, code, oname, ons, opkg, lat);
            chk("fill_nodiag", got, 0);
        end
        send(KL, 0, 16'h0200, 0);
        wait_res(got, lat);
        chk("ovf_diag", got, 1);
        for (int h = 0; h < 5; h++) begin
            chk("ovf_hold", {out_valid, out_code, out_name}, {1'b1, 2'b10, 16'h0200});
            @(negedge clk);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        do_ev(KP, 0, 0, 0, 0, got, code, oname, ons, opkg, lat);
        chk("ovf_summary", {got, code, oname}, {1'b1, 2'b11, 16'd16});

        // ---------------- reset during EMIT ----------------
        do_ev(KE, 0, 16'h3333, 1, 0, got, code, oname, ons, opkg, lat);
        send(KL, 0, 16'h3333, 0);
        wait_res(got, lat);
        chk("rmid_diag", got, 1);
        rst_n = 1'b0;
        #1;
        chk("rmid_out_valid", out_valid, 0);
        chk("rmid_ready_busy", {in_ready, busy}, 2'b10);
        @(negedge clk); rst_n = 1'b1;
        exp_cnt = 0;
        do_ev(KP, 0, 0, 0, 0, got, code, oname, ons, opkg, lat);
        chk("rmid_summary", {got, code, oname}, {1'b1, 2'b11, 16'd0});

        // ---------------- random vs model ----------------
        for (int n = 0; n < 300; n++) begin
            int r;
            r  = $urandom_range(0, 15);
            k  = (r == 0) ? KP : 2'(r % 3);
            nm = 16'h0A00 + 16'($urandom_range(0, 9));
            pk = 4'($urandom_range(0, 3));
            ens = 1'($urandom_range(0, 1));
            model(k, ens, nm, pk, ed, ec, en, ep);
            do_ev(k, ens, nm, pk, $urandom_range(0, 2), got, code, oname, ons, opkg, lat);
            chk("rnd_diag", got, ed);
            if (ed && got) begin
                chk("rnd_code", code, ec);
                chk("rnd_name", oname, en);
                if (ec != 2'b11) chk("rnd_ns", ons, ens);
                if (ec == 2'b01) begin chk("rnd_pkg", opkg, ep); exp_cnt++; end
            end
        end

`ifdef NS_CHECK_COUNT_EN
        chk("conflict_cnt", conflict_cnt, exp_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
